// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester-side handshake bundle for the shared SRAM arbiter.
interface sram_access_arbiter_if;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        pg_req;
    logic [19:0] pg_addr;
    logic [15:0] pg_data;
    logic        pg_gnt;
    logic        bg_req;
    logic [19:0] bg_addr;
    logic [15:0] bg_data;
    logic        bg_gnt;
    logic        busy;
    modport master (
        output rd_req, rd_addr, pg_req, pg_addr, pg_data, bg_req, bg_addr, bg_data,
        input  rd_gnt, rd_data, rd_valid, pg_gnt, bg_gnt, busy
    );
    modport slave (
        input  rd_req, rd_addr, pg_req, pg_addr, pg_data, bg_req, bg_addr, bg_data,
        output rd_gnt, rd_data, rd_valid, pg_gnt, bg_gnt, busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one async 16-bit SRAM between a display reader and two writers.
module sram_access_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int RD_BURST_MAX  = 8
) (
    input  logic                 sram_clk,
    input  logic                 reset,
    sram_access_arbiter_if.slave bus,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic [19:0]          SRAM_ADDR,
    inout  wire  [15:0]          SRAM_DQ
);
    localparam int BW = $clog2(RD_BURST_MAX + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t        state, state_d;
    logic [3:0]    k, k_d;
    logic [BW-1:0] burst, burst_d;
    logic          last_pg, last_pg_d, is_rd, is_rd_d, dq_oe, dq_oe_d;
    logic [19:0]   addr_d;
    logic [15:0]   wdata, wdata_d, rd_data_d;
    logic          ce_n_d, oe_n_d, we_n_d, busy_d;
    logic          rd_gnt_d, pg_gnt_d, bg_gnt_d, rd_valid_d;
    logic          wr_pend, rd_win, pg_win, bg_win;

    assign SRAM_DQ   = dq_oe ? wdata : 'z;
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;

    // Reads win unless they have used up their burst while a writer waits.
    assign wr_pend = bus.pg_req | bus.bg_req;
    assign rd_win  = bus.rd_req && (burst < BW'(RD_BURST_MAX) || !wr_pend);
    assign pg_win  = !rd_win && bus.pg_req && (!bus.bg_req || !last_pg);
    assign bg_win  = !rd_win && bus.bg_req && !pg_win;

    always_comb begin
        state_d    = state;
        k_d        = k;
        burst_d    = burst;
        last_pg_d  = last_pg;
        is_rd_d    = is_rd;
        addr_d     = SRAM_ADDR;
        wdata_d    = wdata;
        rd_data_d  = bus.rd_data;
        dq_oe_d    = dq_oe;
        ce_n_d     = SRAM_CE_N;
        oe_n_d     = SRAM_OE_N;
        we_n_d     = SRAM_WE_N;
        busy_d     = bus.busy;
        rd_gnt_d   = 1'b0;
        pg_gnt_d   = 1'b0;
        bg_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        if (state == IDLE) begin
            if (bus.rd_req || wr_pend) begin
                state_d   = ACCESS;
                k_d       = '0;
                is_rd_d   = rd_win;
                rd_gnt_d  = rd_win;
                pg_gnt_d  = pg_win;
                bg_gnt_d  = bg_win;
                addr_d    = rd_win ? bus.rd_addr : pg_win ? bus.pg_addr : bus.bg_addr;
                wdata_d   = pg_win ? bus.pg_data : bus.bg_data;
                burst_d   = (rd_win && wr_pend) ? (burst == BW'(RD_BURST_MAX) ? burst : burst + 1'b1) : '0;
                last_pg_d = rd_win ? last_pg : pg_win;
                ce_n_d    = 1'b0;
                oe_n_d    = !rd_win;
                we_n_d    = 1'b1;
                dq_oe_d   = !rd_win;
                busy_d    = 1'b1;
            end
        end else if (k == 4'(ACCESS_CYCLES - 1)) begin
            // Final phase: release the bus so the next cycle is a turnaround slot.
            state_d    = IDLE;
            ce_n_d     = 1'b1;
            oe_n_d     = 1'b1;
            we_n_d     = 1'b1;
            dq_oe_d    = 1'b0;
            busy_d     = 1'b0;
            rd_valid_d = is_rd;
            rd_data_d  = is_rd ? SRAM_DQ : bus.rd_data;
        end else begin
            k_d    = k + 1'b1;
            we_n_d = is_rd;
        end
    end

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            burst        <= '0;
            last_pg      <= 1'b0;
            is_rd        <= 1'b0;
            wdata        <= '0;
            dq_oe        <= 1'b0;
            SRAM_CE_N    <= 1'b1;
            SRAM_OE_N    <= 1'b1;
            SRAM_WE_N    <= 1'b1;
            SRAM_ADDR    <= '0;
            bus.rd_gnt   <= 1'b0;
            bus.pg_gnt   <= 1'b0;
            bus.bg_gnt   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_d;
            k            <= k_d;
            burst        <= burst_d;
            last_pg      <= last_pg_d;
            is_rd        <= is_rd_d;
            wdata        <= wdata_d;
            dq_oe        <= dq_oe_d;
            SRAM_CE_N    <= ce_n_d;
            SRAM_OE_N    <= oe_n_d;
            SRAM_WE_N    <= we_n_d;
            SRAM_ADDR    <= addr_d;
            bus.rd_gnt   <= rd_gnt_d;
            bus.pg_gnt   <= pg_gnt_d;
            bus.bg_gnt   <= bg_gnt_d;
            bus.rd_valid <= rd_valid_d;
            bus.rd_data  <= rd_data_d;
            bus.busy     <= busy_d;
        end
    end
endmodule
